// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: data width, ALU function codes and FSM states.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 6;

    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority pointer moves only when upd_en is set.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    input  logic       upd_id,
    output logic [1:0] gnt
);

    // prio names the requester that wins a tie; it is the one not granted last.
    logic prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (upd_en) begin
            prio <= ~upd_id;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt       = 2'b00;
            gnt[prio] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin grant and one operation in flight.
// Defining ALU_ARB_STATS_EN adds saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*DATA_W-1:0]  req_a,
    input  logic [2*DATA_W-1:0]  req_b,
    input  logic [2*FUNC_W-1:0]  req_func,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [FUNC_W-1:0]    alu_func,
    input  logic [DATA_W-1:0]    alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [DATA_W-1:0]    rsp_data
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]          gnt_cnt0,
    output logic [15:0]          gnt_cnt1
`endif
);

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [1:0] gnt;
    logic       grant_en;
    logic       win_id;
    logic       rsp_hs;

    assign grant_en  = (state == ST_IDLE) && (req_valid != 2'b00);
    assign win_id    = gnt[1];
    assign rsp_valid = (state == ST_RESP);
    assign rsp_hs    = rsp_valid && rsp_ready;
    // Gated by rst_n so no grant is visible while the block is held in reset.
    assign req_ready = (grant_en && rst_n) ? gnt : 2'b00;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .upd_en (rsp_hs),
        .upd_id (rsp_id),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (grant_en) next_state = ST_ISSUE;
            ST_ISSUE: if (cnt == 4'd0) next_state = ST_RESP;
            ST_RESP:  if (rsp_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // The operand registers double as the ALU drive, so they hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            cnt      <= 4'd0;
        end else if (grant_en) begin
            alu_a    <= win_id ? req_a[2*DATA_W-1:DATA_W]    : req_a[DATA_W-1:0];
            alu_b    <= win_id ? req_b[2*DATA_W-1:DATA_W]    : req_b[DATA_W-1:0];
            alu_func <= win_id ? req_func[2*FUNC_W-1:FUNC_W] : req_func[FUNC_W-1:0];
            rsp_id   <= win_id;
            cnt      <= LAT_LOAD;
        end else if (state == ST_ISSUE) begin
            if (cnt == 4'd0) begin
                rsp_data <= alu_result;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= 16'd0;
            gnt_cnt1 <= 16'd0;
        end else if (grant_en) begin
            if (!win_id && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (win_id && gnt_cnt1 != 16'hFFFF)  gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) checked against a transaction-level model.
// Grant-counter checks are compiled in only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [1:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [11:0] req_func;
    logic        rsp_ready;

    logic [1:0]  d_req_valid [2];
    logic        d_rsp_ready [2];
    logic [1:0]  d_req_ready [2];
    logic [31:0] d_alu_a     [2];
    logic [31:0] d_alu_b     [2];
    logic [5:0]  d_alu_func  [2];
    logic [31:0] d_alu_res   [2];
    logic        d_rsp_valid [2];
    logic        d_rsp_id    [2];
    logic [31:0] d_rsp_data  [2];
`ifdef ALU_ARB_STATS_EN
    logic [15:0] d_gc0 [2];
    logic [15:0] d_gc1 [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int last_gnt [2];
    int exp_cnt  [2][2];

    always #5 clk = ~clk;

    // Reference ALU; undefined codes fold the code into the result so it is observable.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        case (f)
            FN_ADD:  return a + b;
            FN_SUB:  return a - b;
            FN_AND:  return a & b;
            FN_OR:   return a | b;
            default: return a ^ b ^ {26'd0, f};
        endcase
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 0) ? 1 : 0;
        return v[1] ? 1 : 0;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            d_req_valid[i] = (int'(sel) == i) ? req_valid : 2'b00;
            d_rsp_ready[i] = (int'(sel) == i) ? rsp_ready : 1'b0;
            d_alu_res[i]   = alu_model(d_alu_a[i], d_alu_b[i], d_alu_func[i]);
        end
    end

    alu_arbiter #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid[0]), .req_ready(d_req_ready[0]),
        .req_a(req_a), .req_b(req_b), .req_func(req_func),
        .alu_a(d_alu_a[0]), .alu_b(d_alu_b[0]), .alu_func(d_alu_func[0]), .alu_result(d_alu_res[0]),
        .rsp_valid(d_rsp_valid[0]), .rsp_ready(d_rsp_ready[0]), .rsp_id(d_rsp_id[0]), .rsp_data(d_rsp_data[0])
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt0(d_gc0[0]), .gnt_cnt1(d_gc1[0])
`endif
    );

    alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d_req_valid[1]), .req_ready(d_req_ready[1]),
        .req_a(req_a), .req_b(req_b), .req_func(req_func),
        .alu_a(d_alu_a[1]), .alu_b(d_alu_b[1]), .alu_func(d_alu_func[1]), .alu_result(d_alu_res[1]),
        .rsp_valid(d_rsp_valid[1]), .rsp_ready(d_rsp_ready[1]), .rsp_id(d_rsp_id[1]), .rsp_data(d_rsp_data[1])
`ifdef ALU_ARB_STATS_EN
        , .gnt_cnt0(d_gc0[1]), .gnt_cnt1(d_gc1[1])
`endif
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            last_gnt[d]   = 1;
            exp_cnt[d][0] = 0;
            exp_cnt[d][1] = 0;
        end
    endtask

    task automatic run_op(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0, input logic [5:0] f0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic [5:0] f1,
                          input int stall, output logic got_id, output logic [31:0] got_data);
        int          w;
        int          lat;
        int          cyc;
        logic [1:0]  exp_g;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [5:0]  ef;
        logic [31:0] er;
        lat   = sel ? 3 : 1;
        w     = pick(v, last_gnt[sel]);
        exp_g = (w == 1) ? 2'b10 : 2'b01;
        ea    = w ? a1 : a0;
        eb    = w ? b1 : b0;
        ef    = w ? f1 : f0;
        er    = alu_model(ea, eb, ef);
        @(negedge clk);
        req_valid = v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_func  = {f1, f0};
        rsp_ready = 1'b0;
        #1;
        n_checks++;
        if (d_req_ready[sel] !== exp_g) begin
            n_fail++;
            $display("[TB] FAIL grant dut%0d: req_ready=%b expected %b", sel, d_req_ready[sel], exp_g);
        end
        @(posedge clk);
        #1;
        cyc = 1;
        while (d_rsp_valid[sel] !== 1'b1 && cyc < 40) begin
            n_checks++;
            if (d_req_ready[sel] !== 2'b00 || d_alu_a[sel] !== ea || d_alu_b[sel] !== eb || d_alu_func[sel] !== ef) begin
                n_fail++;
                $display("[TB] FAIL issue dut%0d: ready=%b a=%h b=%h f=%h expected ready=00 a=%h b=%h f=%h",
                         sel, d_req_ready[sel], d_alu_a[sel], d_alu_b[sel], d_alu_func[sel], ea, eb, ef);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (cyc != lat + 1) begin
            n_fail++;
            $display("[TB] FAIL latency dut%0d: rsp_valid after %0d cycles expected %0d", sel, cyc, lat + 1);
        end
        n_checks++;
        if (d_rsp_data[sel] !== er || d_rsp_id[sel] !== w[0]) begin
            n_fail++;
            $display("[TB] FAIL response dut%0d: data=%h id=%b expected data=%h id=%0d",
                     sel, d_rsp_data[sel], d_rsp_id[sel], er, w);
        end
        got_id   = d_rsp_id[sel];
        got_data = d_rsp_data[sel];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (d_rsp_valid[sel] !== 1'b1 || d_rsp_data[sel] !== er || d_rsp_id[sel] !== w[0] ||
                d_req_ready[sel] !== 2'b00 || d_alu_a[sel] !== ea || d_alu_func[sel] !== ef) begin
                n_fail++;
                $display("[TB] FAIL stall dut%0d: valid=%b data=%h id=%b ready=%b a=%h f=%h expected 1 %h %0d 00 %h %h",
                         sel, d_rsp_valid[sel], d_rsp_data[sel], d_rsp_id[sel], d_req_ready[sel],
                         d_alu_a[sel], d_alu_func[sel], er, w, ea, ef);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        last_gnt[sel] = w;
        exp_cnt[sel][w]++;
        n_checks++;
        if (d_rsp_valid[sel] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL handshake dut%0d: rsp_valid=%b expected 0", sel, d_rsp_valid[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sel       = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_func  = '0;
        rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_req_ready[d] !== 2'b00 || d_rsp_valid[d] !== 1'b0 || d_rsp_id[d] !== 1'b0 ||
                d_rsp_data[d] !== 32'd0 || d_alu_a[d] !== 32'd0 || d_alu_b[d] !== 32'd0 || d_alu_func[d] !== 6'd0) begin
                n_fail++;
                $display("[TB] FAIL reset dut%0d: ready=%b valid=%b id=%b data=%h a=%h b=%h f=%h expected all zero",
                         d, d_req_ready[d], d_rsp_valid[d], d_rsp_id[d], d_rsp_data[d], d_alu_a[d], d_alu_b[d], d_alu_func[d]);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b1;
    endtask

    task automatic test_single_add();
        logic        id;
        logic [31:0] data;
        sel = 1'b0;
        run_op(2'b01, 32'd5, 32'd7, FN_ADD, 32'd0, 32'd0, FN_ADD, 0, id, data);
        n_checks++;
        if (data !== 32'd12 || id !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL single_add: data=%0d id=%b expected 12 0", data, id);
        end
    endtask

    task automatic test_round_robin();
        logic        id;
        logic [31:0] data;
        logic [3:0]  order;
        logic [3:0]  want;
        test_reset();
        sel  = 1'b0;
        want = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, $urandom, $urandom, FN_OR, $urandom, $urandom, FN_AND, 0, id, data);
            order[i] = id;
        end
        n_checks++;
        if (order !== want) begin
            n_fail++;
            $display("[TB] FAIL rr_order: ids (op3..op0)=%b expected %b", order, want);
        end
    endtask

    task automatic test_stall();
        logic        id;
        logic [31:0] data;
        sel = 1'b0;
        run_op(2'b10, 32'hDEAD_0000, 32'h0000_BEEF, FN_OR, 32'h1234_5678, 32'h0F0F_0F0F, FN_AND, 5, id, data);
    endtask

    task automatic test_lat3_sub();
        logic        id;
        logic [31:0] data;
        sel = 1'b1;
        run_op(2'b01, 32'd10, 32'd3, FN_SUB, 32'd0, 32'd0, FN_ADD, 2, id, data);
        n_checks++;
        if (data !== 32'd7) begin
            n_fail++;
            $display("[TB] FAIL lat3_sub: data=%0d expected 7", data);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        logic        id;
        logic [31:0] data;
        sel = 1'b0;
        run_op(2'b01, 32'd100, 32'd23, FN_ADD, 32'd0, 32'd0, FN_ADD, 0, id, data);
        @(negedge clk);
        req_valid = 2'b11;
        req_a     = {32'd9, 32'd8};
        req_b     = {32'd1, 32'd2};
        req_func  = {FN_SUB, FN_ADD};
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst_n     = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (d_req_ready[d] !== 2'b00 || d_rsp_valid[d] !== 1'b0 || d_rsp_id[d] !== 1'b0 ||
                d_rsp_data[d] !== 32'd0 || d_alu_a[d] !== 32'd0 || d_alu_b[d] !== 32'd0 || d_alu_func[d] !== 6'd0) begin
                n_fail++;
                $display("[TB] FAIL mid_reset dut%0d: ready=%b valid=%b id=%b data=%h a=%h b=%h f=%h expected all zero",
                         d, d_req_ready[d], d_rsp_valid[d], d_rsp_id[d], d_rsp_data[d], d_alu_a[d], d_alu_b[d], d_alu_func[d]);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (d_rsp_valid[0] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL discard: rsp_valid=%b expected 0 after reset", d_rsp_valid[0]);
            end
        end
        run_op(2'b11, 32'd4, 32'd4, FN_ADD, 32'd6, 32'd6, FN_ADD, 0, id, data);
        n_checks++;
        if (id !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_grant: id=%b expected 0", id);
        end
    endtask

    task automatic test_random();
        logic        id;
        logic [31:0] data;
        logic [1:0]  v;
        logic [5:0]  f [2];
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom_range(0, 1));
            v   = 2'($urandom_range(1, 3));
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0:       f[k] = FN_ADD;
                    1:       f[k] = FN_SUB;
                    2:       f[k] = FN_AND;
                    3:       f[k] = FN_OR;
                    default: f[k] = 6'($urandom);
                endcase
            end
            run_op(v, $urandom, $urandom, f[0], $urandom, $urandom, f[1], $urandom_range(0, 3), id, data);
        end
        sel = 1'b0;
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (int'(d_gc0[d]) != exp_cnt[d][0] || int'(d_gc1[d]) != exp_cnt[d][1]) begin
                n_fail++;
                $display("[TB] FAIL stats dut%0d: cnt0=%0d cnt1=%0d expected %0d %0d",
                         d, d_gc0[d], d_gc1[d], exp_cnt[d][0], exp_cnt[d][1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_stall();
        test_lat3_sub();
        test_reset_mid_issue();
        test_random();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, meaning the number of cycles the ALU operands are held before the result is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2 bits, with bit i meaning requester i presents an operation.
REQ-005 The block SHALL have port req_ready, output, 2 bits, with bit i meaning requester i's operation is accepted this cycle.
REQ-006 The block SHALL have port req_a, input, 64 bits, carrying operand A packed as {req1, req0} with 32 bits each.
REQ-007 The block SHALL have port req_b, input, 64 bits, carrying operand B packed as {req1, req0}.
REQ-008 The block SHALL have port req_func, input, 12 bits, carrying the 6-bit function codes packed as {req1, req0}.
REQ-009 The block SHALL have port alu_a, output, 32 bits, the operand A driven to the shared ALU.
REQ-010 The block SHALL have port alu_b, output, 32 bits, the operand B driven to the shared ALU.
REQ-011 The block SHALL have port alu_func, output, 6 bits, the function code driven to the ALU.
REQ-012 The block SHALL have port alu_result, input, 32 bits, the ALU result.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit, meaning a response is pending.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit, meaning the consumer accepts the response.
REQ-015 The block SHALL have port rsp_id, output, 1 bit, identifying the requester that owns the response.
REQ-016 The block SHALL have port rsp_data, output, 32 bits, the captured ALU result.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and RESP.
REQ-018 In IDLE with any req_valid set, the block SHALL assert req_ready combinationally for the round-robin winner only, latch that winner's a, b and func plus its id, load the counter with ALU_LAT-1, and go to ISSUE.
REQ-019 Round-robin SHALL give priority to the requester not granted last; after reset, req0 SHALL have priority.
REQ-020 In ISSUE, alu_a, alu_b and alu_func SHALL be driven from the latched registers; the counter SHALL decrement each cycle, and on the cycle it equals 0 the block SHALL register alu_result into rsp_data and go to RESP, giving exactly ALU_LAT cycles in ISSUE.
REQ-021 In RESP, rsp_valid SHALL be 1 with rsp_data and rsp_id held stable until rsp_ready; on the handshake the block SHALL update the last-grant pointer and return to IDLE.
REQ-022 req_ready SHALL be 0 in ISSUE and RESP; a new grant SHALL occur no earlier than the cycle after the response handshake, giving minimum spacing ALU_LAT+2 cycles.
REQ-023 Function codes SHALL pass unmodified, including undefined codes.
REQ-024 Outside ISSUE, the alu_* outputs SHALL hold their last values.
REQ-025 A requester deasserting req_valid without a handshake SHALL be legal and SHALL have no effect.
REQ-026 When both requesters are valid, exactly one req_ready bit SHALL be asserted.

Reset
REQ-027 While rst_n=0, the block SHALL force state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a/alu_b=0, alu_func=0, counter=0, and the pointer to favour req0.
REQ-028 Reset asserted during ISSUE or RESP SHALL discard the operation with no response.

Configuration
REQ-029 With ALU_ARB_STATS_EN defined, the block SHALL add output ports gnt_cnt0 and gnt_cnt1, 16 bits each, counting accepted requests per requester, saturating at 16'hFFFF, and reset to 0.
REQ-030 Without ALU_ARB_STATS_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-031 Shared package alu_pkg SHALL hold the function-code constants (AND=6'b100100, OR=6'b100101, ADD=6'b100000, SUB=6'b100010), the 32-bit data width, and the FSM state enum.
REQ-032 Arbitration SHALL be one sub-module, rr_arb2 (2-bit request, one-hot grant, pointer update on an enable input).

Verification
REQ-033 Reset then a single req0 ADD with a=5, b=7, ALU_LAT=1 (ALU model adds) SHALL produce rsp_valid 2 cycles after the grant with rsp_data=12 and rsp_id=0.
REQ-034 Both requesters held valid for 4 operations SHALL produce grant order 0,1,0,1.
REQ-035 rsp_ready held 0 for 5 cycles in RESP SHALL keep rsp_data, rsp_id and rsp_valid stable, with req_ready=0 throughout.
REQ-036 ALU_LAT=3 with SUB a=10, b=3 SHALL hold alu_* stable for 3 cycles and give rsp_data=7.
REQ-037 rst_n pulsed low mid-ISSUE SHALL produce no response, all outputs at reset values, and the next grant going to req0.
REQ-038 With ALU_ARB_STATS_EN, 3 req0 and 2 req1 completions SHALL give gnt_cnt0=3 and gnt_cnt1=2.
